eth_hdr_parser: RTL and testbench
=================================

ETH_HDR_PARSER -- requirements
Module: eth_hdr_parser

Interface
REQ-001 SHALL have parameter MY_MAC, default 48'h00_50_C2_AE_40_01: station address for DST_MATCH.
REQ-002 SHALL have parameter SERVER_MAC, default 48'h00_50_C2_AE_40_00: expected source address for SRC_MATCH.
REQ-003 SHALL have ports (name direction width meaning):
- CLK  in  1  single clock (clk125 domain); all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- IN_ETH_STREAM  in  10  [9]=CKE, [8]=FRM, [7:0]=DAT; frame begins at first destination-MAC byte (preamble/SFD already stripped).
- OUT_ETH_STREAM  out  10  payload-only stream, same format.
- HDR_VALID  out  1  one-cycle pulse when header fields are valid.
- DST_MAC  out  48  destination MAC, first byte in [47:40].
- SRC_MAC  out  48  source MAC, first byte in [47:40].
- ETHERTYPE  out  16  type/length field, first byte in [15:8].
- VLAN_ID  out  12  802.1Q VID (see Configuration).
- DST_MATCH  out  1  DST_MAC==MY_MAC or all-ones.
- SRC_MATCH  out  1  SRC_MAC==SERVER_MAC.
- FRAME_DONE  out  1  one-cycle pulse at end of every frame that was parsed.
- FRAME_LEN  out  16  total bytes of last frame, saturating at 16'hFFFF.
- RUNT_ERR  out  1  one-cycle pulse: frame ended before header complete.

Function
REQ-004 A byte SHALL be consumed only on cycles with CKE=1; CKE=0 cycles SHALL not change state, counters or fields.
REQ-005 States SHALL be SYNC, IDLE, HDR, PAY.
REQ-006 SYNC: SHALL move to IDLE on first CKE=1 cycle with FRM=0; no outputs generated.
REQ-007 IDLE: CKE=1,FRM=1 SHALL store byte as DST_MAC[47:40], set byte index=1, go HDR.
REQ-008 HDR: SHALL shift bytes 0-5 into DST_MAC, 6-11 into SRC_MAC, 12-13 into ETHERTYPE.
REQ-009 On consuming the last header byte SHALL go PAY; HDR_VALID, DST_MATCH, SRC_MATCH SHALL be valid and HDR_VALID high exactly the next cycle.
REQ-010 PAY: each consumed FRM=1 byte SHALL appear on OUT_ETH_STREAM with exactly 1 cycle latency, FRM=1, same DAT.
REQ-011 OUT_ETH_STREAM[9] SHALL equal IN_ETH_STREAM[9] delayed 1 cycle in all states; [8:0] SHALL be zero outside PAY payload cycles.
REQ-012 Frame end (CKE=1,FRM=0) in PAY SHALL go IDLE, output that cycle as CKE=1,FRM=0, and pulse FRAME_DONE next cycle.
REQ-013 Frame end in HDR SHALL go IDLE, pulse RUNT_ERR and FRAME_DONE next cycle, no HDR_VALID, no OUT_ETH_STREAM FRM.
REQ-014 FRAME_LEN SHALL count all consumed FRM=1 bytes including header, 16-bit, saturating at 16'hFFFF (no wrap), updated with FRAME_DONE, held otherwise.
REQ-015 Header fields SHALL hold last values until overwritten by next frame.
REQ-016 A frame with zero payload bytes SHALL produce HDR_VALID and FRAME_DONE, no OUT FRM cycles.
REQ-017 Back-to-back frames separated by a single CKE=1,FRM=0 cycle SHALL both be parsed.

Reset
REQ-018 RST high on any cycle SHALL force SYNC, clear byte index and FRAME_LEN counter, regardless of state.
REQ-019 Reset values: OUT_ETH_STREAM=0, HDR_VALID=0, FRAME_DONE=0, RUNT_ERR=0, DST_MATCH=0, SRC_MATCH=0, DST_MAC=0, SRC_MAC=0, ETHERTYPE=0, VLAN_ID=0, FRAME_LEN=0.
REQ-020 Reset released mid-frame SHALL discard that frame's remainder (SYNC) with no pulses.

Configuration
REQ-021 Macro ETH_HDR_VLAN_EN SHALL select 802.1Q tag handling.
REQ-022 Defined: when bytes 12-13 equal 16'h8100, SHALL consume 4 more header bytes (18 total); VLAN_ID=TCI[11:0], ETHERTYPE=inner type; HDR_VALID after byte 17; untagged frames use 14 bytes and VLAN_ID=0.
REQ-023 Not defined: header always 14 bytes, ETHERTYPE may be 16'h8100, VLAN_ID constant 0, no VLAN logic synthesized.

Verification
REQ-024 64-byte frame, dst=MY_MAC, src=SERVER_MAC, type 16'h0800, CKE=1 always -> HDR_VALID once, DST_MATCH=1, SRC_MATCH=1, 50 payload bytes out 1 cycle delayed, FRAME_LEN=64.
REQ-025 Same frame with CKE=1 every 10th cycle (100 Mbps) -> identical fields/payload; OUT CKE follows input CKE by 1 cycle.
REQ-026 10-byte frame -> RUNT_ERR=1, FRAME_DONE=1, HDR_VALID=0, FRAME_LEN=10, no OUT FRM.
REQ-027 Broadcast dst, other src, then frame with 1-cycle gap -> DST_MATCH=1/SRC_MATCH=0, second frame parsed correctly.
REQ-028 RST asserted at byte 30 of a frame, released at byte 40 -> no pulses until next frame, which parses normally.
REQ-029 ETH_HDR_VLAN_EN defined, tag 8100 0123 0800 -> VLAN_ID=12'h123, ETHERTYPE=16'h0800, payload from byte 18; undefined -> ETHERTYPE=16'h8100, payload from byte 14.

Source files
------------

// File: rtl/eth_hdr_parser.sv
// eth_hdr_parser: extracts DST/SRC/ETHERTYPE from a CKE-gated byte stream and forwards payload with 1-cycle latency.
// No backpressure; CKE=0 cycles are ignored. ETH_HDR_VLAN_EN enables 802.1Q tag parsing (18-byte header).
module eth_hdr_parser #(
  parameter logic [47:0] MY_MAC     = 48'h00_50_C2_AE_40_01,
  parameter logic [47:0] SERVER_MAC = 48'h00_50_C2_AE_40_00
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [9:0]  IN_ETH_STREAM,
  output logic [9:0]  OUT_ETH_STREAM,
  output logic        HDR_VALID,
  output logic [47:0] DST_MAC,
  output logic [47:0] SRC_MAC,
  output logic [15:0] ETHERTYPE,
  output logic [11:0] VLAN_ID,
  output logic        DST_MATCH,
  output logic        SRC_MATCH,
  output logic        FRAME_DONE,
  output logic [15:0] FRAME_LEN,
  output logic        RUNT_ERR
);
  typedef enum logic [1:0] {SYNC, IDLE, HDR, PAY} state_t;
  state_t r_state, w_state_nxt;

  logic        w_cke, w_frm;
  logic [7:0]  w_dat;
  logic        w_hdr_last, w_start, w_hdr_byte, w_pay_byte, w_end_hdr, w_end_pay;
  logic [4:0]  r_idx;
  logic [15:0] r_len_cnt;
  logic [9:0]  r_out;
  logic        r_hdr_valid, r_frame_done, r_runt, r_dst_match, r_src_match;
  logic [47:0] r_dst, r_src;
  logic [15:0] r_type, r_frame_len;

  assign w_cke = IN_ETH_STREAM[9];
  assign w_frm = IN_ETH_STREAM[8];
  assign w_dat = IN_ETH_STREAM[7:0];

`ifdef ETH_HDR_VLAN_EN
  logic [11:0] r_vlan_id;
  logic        w_tagged;
  // Tag decision is made on byte 13 using byte 12 already held in r_type.
  assign w_tagged   = ({r_type[15:8], w_dat} == 16'h8100);
  assign w_hdr_last = ((r_idx == 5'd13) && !w_tagged) || (r_idx == 5'd17);
  assign VLAN_ID    = r_vlan_id;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_vlan_id <= '0;
    end else if (w_hdr_byte) begin
      if (r_idx == 5'd13 && !w_tagged) r_vlan_id <= '0;
      if (r_idx == 5'd14) r_vlan_id[11:8] <= w_dat[3:0];
      if (r_idx == 5'd15) r_vlan_id[7:0] <= w_dat;
    end
  end
`else
  assign w_hdr_last = (r_idx == 5'd13);
  assign VLAN_ID    = 12'h000;
`endif

  always_ff @(posedge CLK) begin
    if (RST) r_state <= SYNC;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_hdr_byte  = 1'b0;
    w_pay_byte  = 1'b0;
    w_end_hdr   = 1'b0;
    w_end_pay   = 1'b0;
    if (w_cke) begin
      case (r_state)
        SYNC: if (!w_frm) w_state_nxt = IDLE;
        IDLE: if (w_frm) begin
          w_start     = 1'b1;
          w_state_nxt = HDR;
        end
        HDR: if (w_frm) begin
          w_hdr_byte = 1'b1;
          if (w_hdr_last) w_state_nxt = PAY;
        end else begin
          w_end_hdr   = 1'b1;
          w_state_nxt = IDLE;
        end
        PAY: if (w_frm) begin
          w_pay_byte = 1'b1;
        end else begin
          w_end_pay   = 1'b1;
          w_state_nxt = IDLE;
        end
        default: w_state_nxt = SYNC;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_idx        <= '0;
      r_len_cnt    <= '0;
      r_out        <= '0;
      r_hdr_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      r_runt       <= 1'b0;
      r_dst_match  <= 1'b0;
      r_src_match  <= 1'b0;
      r_dst        <= '0;
      r_src        <= '0;
      r_type       <= '0;
      r_frame_len  <= '0;
    end else begin
      r_out        <= {w_cke, w_pay_byte, (w_pay_byte ? w_dat : 8'h00)};
      r_hdr_valid  <= w_hdr_byte && w_hdr_last;
      r_frame_done <= w_end_hdr || w_end_pay;
      r_runt       <= w_end_hdr;
      if (w_start) begin
        r_idx        <= 5'd1;
        r_len_cnt    <= 16'd1;
        r_dst[47:40] <= w_dat;
      end
      if ((w_hdr_byte || w_pay_byte) && (r_len_cnt != 16'hFFFF)) r_len_cnt <= r_len_cnt + 16'd1;
      if (w_end_hdr || w_end_pay) r_frame_len <= r_len_cnt;
      if (w_hdr_byte) begin
        r_idx <= r_idx + 5'd1;
        case (r_idx)
          5'd1:  r_dst[39:32] <= w_dat;
          5'd2:  r_dst[31:24] <= w_dat;
          5'd3:  r_dst[23:16] <= w_dat;
          5'd4:  r_dst[15:8]  <= w_dat;
          5'd5:  r_dst[7:0]   <= w_dat;
          5'd6:  r_src[47:40] <= w_dat;
          5'd7:  r_src[39:32] <= w_dat;
          5'd8:  r_src[31:24] <= w_dat;
          5'd9:  r_src[23:16] <= w_dat;
          5'd10: r_src[15:8]  <= w_dat;
          5'd11: r_src[7:0]   <= w_dat;
          5'd12: r_type[15:8] <= w_dat;
          5'd13: r_type[7:0]  <= w_dat;
`ifdef ETH_HDR_VLAN_EN
          5'd16: r_type[15:8] <= w_dat;
          5'd17: r_type[7:0]  <= w_dat;
`endif
          default: ;
        endcase
        // Both addresses are complete before the last header byte arrives.
        if (w_hdr_last) begin
          r_dst_match <= (r_dst == MY_MAC) || (&r_dst);
          r_src_match <= (r_src == SERVER_MAC);
        end
      end
    end
  end

  assign OUT_ETH_STREAM = r_out;
  assign HDR_VALID      = r_hdr_valid;
  assign DST_MAC        = r_dst;
  assign SRC_MAC        = r_src;
  assign ETHERTYPE      = r_type;
  assign DST_MATCH      = r_dst_match;
  assign SRC_MATCH      = r_src_match;
  assign FRAME_DONE     = r_frame_done;
  assign FRAME_LEN      = r_frame_len;
  assign RUNT_ERR       = r_runt;
endmodule

// File: tb/tb_eth_hdr_parser.sv
// Bench for eth_hdr_parser: frame table plus random frames checked cycle-by-cycle against a frame-level model.
module tb_eth_hdr_parser;
  localparam logic [47:0] MY_MAC     = 48'h0050C2AE4001;
  localparam logic [47:0] SERVER_MAC = 48'h0050C2AE4000;
`ifdef ETH_HDR_VLAN_EN
  localparam logic [15:0] VLAN_TYPE = 16'h0800;
  localparam logic [11:0] VLAN_VID  = 12'h123;
`else
  localparam logic [15:0] VLAN_TYPE = 16'h8100;
  localparam logic [11:0] VLAN_VID  = 12'h000;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [9:0]  IN_ETH_STREAM = '0;
  logic [9:0]  OUT_ETH_STREAM;
  logic        HDR_VALID, DST_MATCH, SRC_MATCH, FRAME_DONE, RUNT_ERR;
  logic [47:0] DST_MAC, SRC_MAC;
  logic [15:0] ETHERTYPE, FRAME_LEN;
  logic [11:0] VLAN_ID;

  eth_hdr_parser #(.MY_MAC(MY_MAC), .SERVER_MAC(SERVER_MAC)) dut (
    .CLK(CLK), .RST(RST), .IN_ETH_STREAM(IN_ETH_STREAM), .OUT_ETH_STREAM(OUT_ETH_STREAM),
    .HDR_VALID(HDR_VALID), .DST_MAC(DST_MAC), .SRC_MAC(SRC_MAC), .ETHERTYPE(ETHERTYPE),
    .VLAN_ID(VLAN_ID), .DST_MATCH(DST_MATCH), .SRC_MATCH(SRC_MATCH), .FRAME_DONE(FRAME_DONE),
    .FRAME_LEN(FRAME_LEN), .RUNT_ERR(RUNT_ERR)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;
  int hv_cnt = 0;
  int runt_cnt = 0;
  logic [7:0] fq[$];

  typedef struct {
    int          len;
    logic [47:0] dst;
    logic [47:0] src;
    logic [15:0] typ;
    int          period;
    int          exp_hv;
    int          exp_runt;
    logic        exp_dm;
    logic        exp_sm;
    logic [15:0] exp_type;
    logic [11:0] exp_vid;
    logic [15:0] exp_len;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one cycle, then compare {OUT, HDR_VALID, FRAME_DONE, RUNT_ERR} just after the edge.
  task automatic tick(input logic [9:0] din, input logic [12:0] exp, input string nm);
    IN_ETH_STREAM = din;
    @(posedge CLK);
    #1;
    if (HDR_VALID === 1'b1) hv_cnt++;
    if (RUNT_ERR === 1'b1) runt_cnt++;
    chk(nm, 64'({OUT_ETH_STREAM, HDR_VALID, FRAME_DONE, RUNT_ERR}), 64'(exp));
  endtask

  function automatic int hdr_len_of();
`ifdef ETH_HDR_VLAN_EN
    if (fq.size() >= 14 && {fq[12], fq[13]} == 16'h8100) return 18;
`endif
    return 14;
  endfunction

  task automatic build_frame(input int len, input logic [47:0] dst, input logic [47:0] src,
                             input logic [15:0] typ);
    fq.delete();
    for (int k = 0; k < 6; k++) fq.push_back(dst[47-8*k -: 8]);
    for (int k = 0; k < 6; k++) fq.push_back(src[47-8*k -: 8]);
    fq.push_back(typ[15:8]);
    fq.push_back(typ[7:0]);
    while (fq.size() < len) fq.push_back(8'($urandom));
    while (fq.size() > len) void'(fq.pop_back());
  endtask

  task automatic check_zero_fields(input string nm);
    chk({nm, "_dst"}, 64'(DST_MAC), 64'h0);
    chk({nm, "_src"}, 64'(SRC_MAC), 64'h0);
    chk({nm, "_type_vid_len"}, 64'({ETHERTYPE, VLAN_ID, FRAME_LEN}), 64'h0);
    chk({nm, "_match"}, 64'({DST_MATCH, SRC_MATCH}), 64'h0);
  endtask

  // Sends fq as one frame with CKE every 'period' cycles, followed by one end cycle.
  // rst_at >= 0 holds RST high for bytes rst_at..rst_at+9.
  task automatic send_frame(input int period, input int rst_at);
    int          n = fq.size();
    int          hl = hdr_len_of();
    bit          parsed = (n >= hl);
    bit          killed = 1'b0;
    logic [47:0] edst = '0;
    logic [47:0] esrc = '0;
    logic [15:0] etype = '0;
    logic [11:0] evid = '0;
    logic [12:0] e;
    if (parsed) begin
      for (int k = 0; k < 6; k++) begin
        edst = {edst[39:0], fq[k]};
        esrc = {esrc[39:0], fq[k+6]};
      end
      etype = {fq[hl-2], fq[hl-1]};
      if (hl == 18) evid = {fq[14][3:0], fq[15]};
    end
    for (int i = 0; i < n; i++) begin
      for (int g = 1; g < period; g++) tick({1'b0, 9'($urandom)}, 13'h0, "cke_idle");
      if (rst_at >= 0 && i == rst_at) begin RST = 1'b1; killed = 1'b1; end
      if (rst_at >= 0 && i == rst_at + 10) RST = 1'b0;
      if (RST) e = 13'h0;
      else if (killed || i < hl) e = {10'h200, 3'b000};
      else e = {2'b11, fq[i], 3'b000};
      if (!killed && i == hl - 1) e[2] = 1'b1;
      tick({2'b11, fq[i]}, e, "byte");
      if (rst_at >= 0 && i == rst_at + 9) check_zero_fields("midrst");
      if (!killed && parsed && i == hl - 1) begin
        chk("dst_mac", 64'(DST_MAC), 64'(edst));
        chk("src_mac", 64'(SRC_MAC), 64'(esrc));
        chk("ethertype", 64'(ETHERTYPE), 64'(etype));
        chk("vlan_id", 64'(VLAN_ID), 64'(evid));
        chk("dst_match", 64'(DST_MATCH), 64'((edst == MY_MAC) || (edst == 48'hFFFF_FFFF_FFFF)));
        chk("src_match", 64'(SRC_MATCH), 64'(esrc == SERVER_MAC));
      end
    end
    for (int g = 1; g < period; g++) tick({1'b0, 9'($urandom)}, 13'h0, "cke_idle");
    if (killed) e = {10'h200, 3'b000};
    else e = {10'h200, 1'b0, 1'b1, !parsed};
    tick(10'h200, e, "frame_end");
    chk("frame_len", 64'(FRAME_LEN), killed ? 64'h0 : (n > 65535 ? 64'hFFFF : 64'(n)));
  endtask

  initial begin
    tbl[0] = '{64, MY_MAC, SERVER_MAC, 16'h0800, 1, 1, 0, 1'b1, 1'b1, 16'h0800, 12'h0, 16'd64};
    tbl[1] = '{64, MY_MAC, SERVER_MAC, 16'h0800, 10, 1, 0, 1'b1, 1'b1, 16'h0800, 12'h0, 16'd64};
    tbl[2] = '{10, MY_MAC, SERVER_MAC, 16'h0800, 1, 0, 1, 1'b1, 1'b1, 16'h0800, 12'h0, 16'd10};
    tbl[3] = '{60, 48'hFFFF_FFFF_FFFF, 48'h0011_2233_4455, 16'h0806, 1, 1, 0, 1'b1, 1'b0, 16'h0806, 12'h0, 16'd60};
    tbl[4] = '{14, 48'h0200_0000_0001, SERVER_MAC, 16'h88B5, 1, 1, 0, 1'b0, 1'b1, 16'h88B5, 12'h0, 16'd14};
    tbl[5] = '{12, MY_MAC, 48'h0011_2233_4455, 16'h1234, 1, 0, 1, 1'b0, 1'b1, 16'h88B5, 12'h0, 16'd12};
    tbl[6] = '{64, MY_MAC, SERVER_MAC, 16'h8100, 1, 1, 0, 1'b1, 1'b1, VLAN_TYPE, VLAN_VID, 16'd64};

    // Reset must win over an active input; then SYNC waits for an FRM=0 byte.
    tick(10'h3FF, 13'h0, "rst_out");
    tick(10'h3FF, 13'h0, "rst_out");
    check_zero_fields("reset");
    RST = 1'b0;
    tick(10'h000, 13'h0, "sync_cke0");
    tick(10'h3AB, {10'h200, 3'b000}, "sync_frm1");
    tick(10'h200, {10'h200, 3'b000}, "sync_exit");
    tick(10'h1CD, 13'h0, "idle_cke0");

    for (int t = 0; t < 7; t++) begin
      build_frame(tbl[t].len, tbl[t].dst, tbl[t].src, tbl[t].typ);
      if (tbl[t].typ == 16'h8100 && tbl[t].len >= 18) begin
        fq[14] = 8'h01; fq[15] = 8'h23; fq[16] = 8'h08; fq[17] = 8'h00;
      end
      hv_cnt = 0;
      runt_cnt = 0;
      send_frame(tbl[t].period, -1);
      chk("tbl_hv_count", 64'(hv_cnt), 64'(tbl[t].exp_hv));
      chk("tbl_runt_count", 64'(runt_cnt), 64'(tbl[t].exp_runt));
      chk("tbl_match", 64'({DST_MATCH, SRC_MATCH}), 64'({tbl[t].exp_dm, tbl[t].exp_sm}));
      chk("tbl_type", 64'(ETHERTYPE), 64'(tbl[t].exp_type));
      chk("tbl_vid", 64'(VLAN_ID), 64'(tbl[t].exp_vid));
      chk("tbl_len", 64'(FRAME_LEN), 64'(tbl[t].exp_len));
    end

    // Reset across bytes 30..39, then a normal frame right after.
    build_frame(64, MY_MAC, SERVER_MAC, 16'h0800);
    hv_cnt = 0;
    send_frame(1, 30);
    chk("rst_frame_hv", 64'(hv_cnt), 64'd1);
    build_frame(40, 48'hFFFF_FFFF_FFFF, SERVER_MAC, 16'h0806);
    hv_cnt = 0;
    send_frame(1, -1);
    chk("post_rst_hv", 64'(hv_cnt), 64'd1);

    for (int r = 0; r < 40; r++) begin
      logic [47:0] d, s;
      logic [15:0] ty;
      case ($urandom_range(0, 2))
        0: d = MY_MAC;
        1: d = 48'hFFFF_FFFF_FFFF;
        default: d = 48'({$urandom(), $urandom()});
      endcase
      s = ($urandom_range(0, 1) == 0) ? SERVER_MAC : 48'({$urandom(), $urandom()});
      ty = ($urandom_range(0, 3) == 0) ? 16'h8100 : 16'($urandom());
      build_frame($urandom_range(8, 90), d, s, ty);
      repeat ($urandom_range(0, 2)) tick(10'h200, {10'h200, 3'b000}, "gap");
      send_frame($urandom_range(1, 3), -1);
    end

    build_frame(65540, MY_MAC, SERVER_MAC, 16'h0800);
    send_frame(1, -1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
